// File: rtl/mult_pkg.sv
// Shared definitions for the frame-synchronised multiplier: state encoding and default widths.
package mult_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        DONE = 3'b100
    } state_t;

endpackage

// File: rtl/frame_multiplier_if.sv
// Video timing, operand and result bundle for frame_multiplier; the slave modport is the multiplier side.
interface frame_multiplier_if
    import mult_pkg::*;
#(
    parameter int N = N_DEF
);
    localparam int W = 2 * N;

    logic         i_hs;
    logic         i_vs;
    logic         i_de;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic [W-1:0] product;
    logic         o_valid;
    logic         o_busy;
    logic         o_hsync;
    logic         o_vsync;
    logic         o_de;

    modport master (
        output i_hs, i_vs, i_de, multiplicand, multiplier,
        input  product, o_valid, o_busy, o_hsync, o_vsync, o_de
    );

    modport slave (
        input  i_hs, i_vs, i_de, multiplicand, multiplier,
        output product, o_valid, o_busy, o_hsync, o_vsync, o_de
    );

endinterface

// File: rtl/vid_sync_delay.sv
// One-cycle delay of hs/vs/de plus the vertical-sync falling-edge detector that starts a multiply.
module vid_sync_delay (
    input  logic pixelclk,
    input  logic rst_n,
    input  logic i_hs,
    input  logic i_vs,
    input  logic i_de,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_de,
    output logic vs_fall
);

    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic de_q, de_d;

    always_comb begin
        hs_d = i_hs;
        vs_d = i_vs;
        de_d = i_de;
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
        end
    end

    // The delayed vsync doubles as the edge-detector history bit.
    assign vs_fall = vs_q & ~i_vs;

    assign o_hsync = hs_q;
    assign o_vsync = vs_q;
    assign o_de    = de_q;

endmodule

// File: rtl/frame_multiplier.sv
// Shift-and-add multiplier started by a vsync falling edge; product held until the next completion.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module frame_multiplier
    import mult_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input logic               pixelclk,
    input logic               rst_n,
    frame_multiplier_if.slave bus
);

    localparam int CW = $clog2(N + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  product_q, product_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  mag_a, mag_b;
    logic [N:0]    sum;
    logic          vs_fall;

    vid_sync_delay u_sync (
        .pixelclk (pixelclk),
        .rst_n    (rst_n),
        .i_hs     (bus.i_hs),
        .i_vs     (bus.i_vs),
        .i_de     (bus.i_de),
        .o_hsync  (bus.o_hsync),
        .o_vsync  (bus.o_vsync),
        .o_de     (bus.o_de),
        .vs_fall  (vs_fall)
    );

`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;

    // The most negative operand maps to magnitude 2^(N-1), which still fits N unsigned bits.
    assign mag_a = bus.multiplicand[N-1] ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
    assign mag_b = bus.multiplier[N-1]   ? (~bus.multiplier + 1'b1)   : bus.multiplier;
`else
    assign mag_a = bus.multiplicand;
    assign mag_b = bus.multiplier;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        valid_d   = 1'b0;
        sum       = {1'b0, acc_q[W-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (vs_fall) begin
                    mcand_d = mag_a;
                    acc_d   = {{N{1'b0}}, mag_b};
                    cnt_d   = CW'(N);
                    state_d = CALC;
`ifdef MULT_SIGNED_EN
                    sign_d  = bus.multiplicand[N-1] ^ bus.multiplier[N-1];
`endif
                end
            end
            CALC: begin
                acc_d = {sum, acc_q[N-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef MULT_SIGNED_EN
                product_d = sign_q ? (~acc_q + 1'b1) : acc_q;
`else
                product_d = acc_q;
`endif
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

`ifdef MULT_SIGNED_EN
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end
`endif

    assign bus.product = product_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_frame_multiplier.sv
// Scoreboard bench for frame_multiplier: a cycle-level behavioural model queues expected products,
// a negedge monitor compares results, busy, and sync passthrough.
module tb_frame_multiplier;

    localparam int N = 16;
    localparam int W = 32;

    logic pixelclk = 1'b0;
    logic rst_n    = 1'b1;

    always #5 pixelclk = ~pixelclk;

    frame_multiplier_if #(.N(N)) bus ();

    frame_multiplier #(.N(N), .W(W)) dut (
        .pixelclk (pixelclk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [W-1:0] p;
        int           edge_n;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc    = 0;

    // Behavioural model state
    logic         m_vs_prev = 1'b0;
    bit           m_act     = 1'b0;
    int           m_start   = 0;
    logic         m_hs = 1'b0, m_vs = 1'b0, m_de = 1'b0;
    logic [W-1:0] m_prod = '0;

    function automatic logic [W-1:0] ref_mul(logic [N-1:0] a, logic [N-1:0] b);
        longint sa;
        longint sb;
`ifdef MULT_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return W'(sa * sb);
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: a vsync fall is accepted only when no multiply is running or finishing.
    always @(posedge pixelclk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            m_vs_prev = 1'b0;
            m_act     = 1'b0;
            m_hs      = 1'b0;
            m_vs      = 1'b0;
            m_de      = 1'b0;
            m_prod    = '0;
            q.delete();
        end else begin
            m_hs = bus.i_hs;
            m_vs = bus.i_vs;
            m_de = bus.i_de;
            if (m_vs_prev && !bus.i_vs && (!m_act || cyc > m_start + N + 1)) begin
                m_act    = 1'b1;
                m_start  = cyc;
                e.p      = ref_mul(bus.multiplicand, bus.multiplier);
                e.edge_n = cyc + N + 1;
                q.push_back(e);
            end
            m_vs_prev = bus.i_vs;
        end
    end

    always @(negedge pixelclk) begin
        bit valid_exp;
        bit busy_exp;
        while (q.size() > 0 && q[0].edge_n < cyc) void'(q.pop_front());
        valid_exp = (q.size() > 0) && (q[0].edge_n == cyc);
        busy_exp  = m_act && (cyc >= m_start) && (cyc <= m_start + N);
        chk("o_valid", W'(bus.o_valid), W'(valid_exp));
        if (valid_exp) begin
            m_prod = q[0].p;
            void'(q.pop_front());
        end
        chk("product", bus.product, m_prod);
        chk("o_busy", W'(bus.o_busy), W'(busy_exp));
        chk("o_hsync", W'(bus.o_hsync), W'(m_hs));
        chk("o_vsync", W'(bus.o_vsync), W'(m_vs));
        chk("o_de", W'(bus.o_de), W'(m_de));
    end

    task automatic step(logic hs, logic vs, logic de, logic [N-1:0] a, logic [N-1:0] b);
        @(negedge pixelclk);
        #1;
        bus.i_hs         = hs;
        bus.i_vs         = vs;
        bus.i_de         = de;
        bus.multiplicand = a;
        bus.multiplier   = b;
    endtask

    task automatic rnd_step(logic vs);
        step(1'($urandom), vs, 1'($urandom), N'($urandom), N'($urandom));
    endtask

    task automatic start_mult(logic [N-1:0] a, logic [N-1:0] b);
        rnd_step(1'b1);
        step(1'($urandom), 1'b0, 1'($urandom), a, b);
    endtask

    task automatic run_mult(logic [N-1:0] a, logic [N-1:0] b);
        start_mult(a, b);
        repeat (N + 3) rnd_step(1'b0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_product"}, bus.product, '0);
        chk({tag, "_o_valid"}, W'(bus.o_valid), '0);
        chk({tag, "_o_busy"},  W'(bus.o_busy), '0);
        chk({tag, "_o_hsync"}, W'(bus.o_hsync), '0);
        chk({tag, "_o_vsync"}, W'(bus.o_vsync), '0);
        chk({tag, "_o_de"},    W'(bus.o_de), '0);
    endtask

    initial begin
        bus.i_hs         = 1'b0;
        bus.i_vs         = 1'b0;
        bus.i_de         = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge pixelclk);
        #1 rst_n = 1'b1;

        run_mult(16'h0003, 16'h0005);
        run_mult(16'hFFFF, 16'hFFFF);
        run_mult(16'h0000, 16'h1234);
        run_mult(16'h8000, 16'h8000);
        run_mult(16'h8000, 16'h0001);
        run_mult(16'hFFFD, 16'h0004);

        // Second fall at E5 with new operands must be ignored.
        start_mult(16'h1111, 16'h0022);
        rnd_step(1'b0);
        rnd_step(1'b0);
        rnd_step(1'b1);
        rnd_step(1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h7777, 16'h9999);
        repeat (N) rnd_step(1'b0);
        run_mult(16'hABCD, 16'h0F0F);

        // Reset in the middle of a multiply discards it.
        start_mult(16'h4321, 16'h00FF);
        repeat (7) rnd_step(1'b0);
        @(negedge pixelclk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(negedge pixelclk);
        #1 rst_n = 1'b1;
        run_mult(16'h0102, 16'h0304);

        // Random traffic, vsync included, so starts collide with busy periods.
        repeat (800) rnd_step(1'($urandom_range(0, 1)));
        repeat (3) run_mult(N'($urandom), N'($urandom));
        step(1'b0, 1'b1, 1'b0, '0, '0);

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge pixelclk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: %0d products outstanding, required 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
